// File: rtl/debounce_pkg.sv
// ============================================================================
// Module   : debounce_pkg
// Purpose  : State encoding and default timing shared by input conditioners.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

    // 1 ms at the 12 MHz board clock; also used by other input conditioners.
    localparam int DEBOUNCE_STABLE_CYCLES = 12000;
    localparam int DEBOUNCE_CNT_W         = 14;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser for an asynchronous pin, sync reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module   : button_debounce
// Purpose  : Synchronise and debounce a push-button; optional edge pulses
//            enabled by defining BUTTON_DEBOUNCE_EDGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES,
    parameter int CNT_W         = DEBOUNCE_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic db_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic             w_s2;
    logic             w_done;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             r_busy;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (w_s2)
    );

    assign w_done = (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOW: begin
                    if (w_s2) begin
                        r_state <= ST_WAIT_HIGH;
                        r_cnt   <= C_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!w_s2) begin
                        r_state <= ST_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_done) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= '0;
                        r_db    <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!w_s2) begin
                        r_state <= ST_WAIT_LOW;
                        r_cnt   <= C_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT_LOW: begin
                    if (w_s2) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_done) begin
                        r_state <= ST_LOW;
                        r_cnt   <= '0;
                        r_db    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= ST_LOW;
                    r_cnt   <= '0;
                    r_db    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign db_out = r_db;
    assign busy   = r_busy;

`ifdef BUTTON_DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulses are set on the same edge that commits db_out, so they line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= (r_state == ST_WAIT_HIGH) && w_s2 && w_done;
            r_fall <= (r_state == ST_WAIT_LOW) && !w_s2 && w_done;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// ============================================================================
// Module   : tb_button_debounce
// Purpose  : Self-checking bench for button_debounce with STABLE_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debounce;

    localparam int STABLE = 4;
`ifdef BUTTON_DEBOUNCE_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic db_out, rise, fall, busy;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // Reference: the FSM sees btn two edges late; db_out flips after
    // STABLE consecutive observed samples that disagree with it.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0;
    logic m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0;
    int   m_run = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (14)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .db_out (db_out),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic b, input logic r);
        logic seen;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
            m_rise = 0; m_fall = 0; m_busy = 0;
        end else begin
            seen   = m_s2;
            m_s2   = m_s1;
            m_s1   = b;
            m_rise = 0;
            m_fall = 0;
            if (seen != m_db) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_db   = ~m_db;
                    m_rise = m_db;
                    m_fall = ~m_db;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            m_busy = (m_run != 0);
        end
    endtask

    task automatic cyc(input logic b, input logic r);
        btn = b;
        rst = r;
        @(posedge clk);
        model_step(b, r);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_db",   db_out, m_db);
            chk("model_rise", rise,   m_rise & EDGE);
            chk("model_fall", fall,   m_fall & EDGE);
            chk("model_busy", busy,   m_busy);
        end
    end

    initial begin
        bit   any_bad;
        logic b;
        int   hold;

        cyc(1'b0, 1'b1);
        cmp_en = 1'b1;
        cyc(1'b0, 1'b1);
        chk("reset_db", db_out, 1'b0);
        chk("reset_rise", rise, 1'b0);
        chk("reset_fall", fall, 1'b0);
        chk("reset_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);

        // Clean press: edge index i is the i-th edge sampling btn=1.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 1) chk("press_busy_e1", busy, 1'b0);
            if (i >= 2 && i <= 4) chk("press_busy_e2_4", busy, 1'b1);
            if (i == 4) chk("press_db_e4", db_out, 1'b0);
            if (i == 5) begin
                chk("press_db_e5", db_out, 1'b1);
                chk("press_rise_e5", rise, EDGE);
                chk("press_busy_e5", busy, 1'b0);
            end
            if (i == 6) chk("press_rise_e6", rise, 1'b0);
        end

        // Clean release.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0);
            if (i == 4) chk("release_db_e4", db_out, 1'b1);
            if (i == 5) begin
                chk("release_db_e5", db_out, 1'b0);
                chk("release_fall_e5", fall, EDGE);
                chk("release_rise_e5", rise, 1'b0);
            end
            if (i == 6) chk("release_fall_e6", fall, 1'b0);
        end

        // Bounce: runs of STABLE-1 highs never qualify.
        any_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc((i % 4) != 3, 1'b0);
            if (db_out || rise) any_bad = 1'b1;
        end
        chk("bounce_no_change", any_bad, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

        // Press, then a one-cycle low glitch.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
        chk("glitch_pre_db", db_out, 1'b1);
        cyc(1'b0, 1'b0);
        any_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0);
            if (!db_out || fall) any_bad = 1'b1;
        end
        chk("glitch_no_fall", any_bad, 1'b0);

        // Reset mid-count of a press.
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        chk("midrst_busy_before", busy, 1'b1);
        cyc(1'b1, 1'b1);
        chk("midrst_db", db_out, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rise", rise, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 4) chk("midrst_db_e4", db_out, 1'b0);
            if (i == 5) begin
                chk("midrst_db_e5", db_out, 1'b1);
                chk("midrst_rise_e5", rise, EDGE);
            end
        end

        // Random runs with occasional resets, checked by the model.
        b = 1'b0;
        for (int i = 0; i < 600; i++) begin
            b    = ~b;
            hold = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++)
                cyc(b, ($urandom_range(0, 199) == 0));
        end
        cyc(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
